// File: rtl/ram_port_arbiter.sv
// Two-port arbiter/sequencer for the shared single-port system RAM.
// Port A (CPU) has fixed priority; a saturating wait counter bounds port B starvation.
module ram_port_arbiter #(
   parameter int MAX_WAIT = 4,
   parameter int AW       = 15
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          a_req,
   input  logic          a_we,
   input  logic [AW-1:0] a_addr,
   input  logic [7:0]    a_wdata,
   output logic          a_ack,
   output logic [7:0]    a_rdata,
   input  logic          b_req,
   input  logic          b_we,
   input  logic [AW-1:0] b_addr,
   input  logic [7:0]    b_wdata,
   output logic          b_ack,
   output logic [7:0]    b_rdata,
   output logic          ram_we,
   output logic [AW-1:0] ram_addr,
   output logic [7:0]    ram_din,
   input  logic [7:0]    ram_dout
);

   // state   | meaning
   // IDLE    | arbitrate; acks from the previous access are visible here
   // SERVE_A | RAM driven with port A's access for one cycle
   // SERVE_B | RAM driven with port B's access for one cycle
   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SERVE_A = 2'd1,
      SERVE_B = 2'd2
   } state_t;

   localparam logic [3:0] WAIT_MAX = 4'(MAX_WAIT);

   state_t     state;
   logic [3:0] wait_cnt;
   logic       a_elig;
   logic       b_elig;
   logic       b_due;
   logic       grant_a;
   logic       grant_b;

   // A requester is masked during its own ack cycle so a held req is not re-granted.
   always_comb begin
      a_elig  = a_req & ~a_ack;
      b_elig  = b_req & ~b_ack;
      b_due   = b_elig && (wait_cnt == WAIT_MAX);
      grant_b = (state == IDLE) && (b_due || (b_elig && !a_elig));
      grant_a = (state == IDLE) && a_elig && !b_due;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         wait_cnt <= 4'd0;
         ram_we   <= 1'b0;
         ram_addr <= '0;
         ram_din  <= 8'h00;
         a_ack    <= 1'b0;
         b_ack    <= 1'b0;
         a_rdata  <= 8'h00;
         b_rdata  <= 8'h00;
      end else begin
         a_ack <= 1'b0;
         b_ack <= 1'b0;

         if (grant_b) begin
            wait_cnt <= 4'd0;
         end else if (b_elig && (wait_cnt < WAIT_MAX)) begin
            wait_cnt <= wait_cnt + 4'd1;
         end

         case (state)
            IDLE: begin
               if (grant_b) begin
                  state    <= SERVE_B;
                  ram_addr <= b_addr;
                  ram_din  <= b_wdata;
                  ram_we   <= b_we;
               end else if (grant_a) begin
                  state    <= SERVE_A;
                  ram_addr <= a_addr;
                  ram_din  <= a_wdata;
                  ram_we   <= a_we;
               end
            end
            SERVE_A: begin
               state  <= IDLE;
               a_ack  <= 1'b1;
               ram_we <= 1'b0;
               if (!ram_we) begin
                  a_rdata <= ram_dout;
               end
            end
            SERVE_B: begin
               state  <= IDLE;
               b_ack  <= 1'b1;
               ram_we <= 1'b0;
               if (!ram_we) begin
                  b_rdata <= ram_dout;
               end
            end
            default: begin
               state  <= IDLE;
               ram_we <= 1'b0;
            end
         endcase
      end
   end

endmodule
